// File: rtl/noc_axi4_bridge_ser_fifo.sv
// noc_axi4_bridge_ser_fifo: response serializer for the NoC-AXI4 bridge.
// Buffers up to FIFO_DEPTH completed transactions (header + one AXI beat).
// Each buffered transaction leaves as one header flit plus 0..AXI_DATA_W/NOC_DATA_W data flits.
// Back-to-back packets stream with no idle cycle between them.
// Optional feature macro: NOC_AXI4_BRIDGE_SER_ERR_EN (unsupported request types raise err_pulse).
// Request header fields (HDR_W >= 192):
//   [191:178] SRC_CHIPID, [177:170] SRC_X, [169:162] SRC_Y, [161:158] SRC_FBITS,
//   [122:120] size_log (log2 of access bytes), [21:14] MSG_TYPE, [13:6] MSHRID.
// Response header flit (64b): {DST_CHIPID, DST_X, DST_Y, DST_FBITS, LENGTH, MSG_TYPE, MSHRID, OPTIONS_1}.
module noc_axi4_bridge_ser_fifo #(
  parameter int AXI_DATA_W     = 512,
  parameter int NOC_DATA_W     = 64,
  parameter int HDR_W          = 192,
  parameter int FIFO_DEPTH     = 2,
  parameter int SWAP_ENDIANESS = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [HDR_W-1:0]                header_in,
  input  logic [AXI_DATA_W-1:0]           data_in,
  input  logic                            in_val,
  output logic                            in_rdy,
  output logic [NOC_DATA_W-1:0]           flit_out,
  output logic                            flit_out_val,
  input  logic                            flit_out_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt,
  output logic                            err_pulse
);

  localparam int NBEATS   = AXI_DATA_W / NOC_DATA_W;
  localparam int NB_BYTES = NOC_DATA_W / 8;
  localparam int NB_LOG   = $clog2(NB_BYTES);
  localparam int BEAT_LOG = $clog2(NBEATS);
  localparam int IW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int BW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [BW-1:0] BEAT_ONE = BW'(1'b1);
  localparam logic [IW:0]   PTR_ONE  = (IW + 1)'(1'b1);

  localparam logic [7:0] MSG_NC_LOAD_REQ      = 8'd14;
  localparam logic [7:0] MSG_NC_STORE_REQ     = 8'd15;
  localparam logic [7:0] MSG_LOAD_MEM         = 8'd19;
  localparam logic [7:0] MSG_STORE_MEM        = 8'd20;
  localparam logic [7:0] MSG_LOAD_MEM_ACK     = 8'd24;
  localparam logic [7:0] MSG_STORE_MEM_ACK    = 8'd25;
  localparam logic [7:0] MSG_NC_LOAD_MEM_ACK  = 8'd26;
  localparam logic [7:0] MSG_NC_STORE_MEM_ACK = 8'd27;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2} state_t;

  // Number of data flits for a non-cacheable load of 2^sl bytes, saturated at one full beat.
  function automatic logic [7:0] nc_length(input logic [2:0] sl);
    int ex;
    ex = int'(sl) - NB_LOG;
    if (ex <= 0) return 8'd1;
    else if (ex >= BEAT_LOG) return 8'(NBEATS);
    else return 8'(1 << ex);
  endfunction

  // Byte-swap chunk size (log2 bytes): the access size, capped at one flit.
  function automatic logic [2:0] chunk_log(input logic [2:0] sl);
    if (int'(sl) < NB_LOG) return sl;
    else return 3'(NB_LOG);
  endfunction

  // Reverse bytes inside aligned power-of-two chunks: byte i takes byte i XOR (chunk-1).
  function automatic logic [NOC_DATA_W-1:0] swap_bytes(input logic [NOC_DATA_W-1:0] d,
                                                       input logic [2:0] cl);
    logic [NOC_DATA_W-1:0] r;
    int m;
    m = (1 << int'(cl)) - 1;
    r = {NOC_DATA_W{1'b0}};
    for (int i = 0; i < NB_BYTES; i++) r[8*i +: 8] = d[8*(i ^ m) +: 8];
    return r;
  endfunction

  state_t          state_r;
  logic [BW-1:0]   beat_r;
  logic [IW:0]     wr_ptr_r, rd_ptr_r;
  logic [63:0]     hdr_mem_r   [FIFO_DEPTH];
  logic [2:0]      chunk_mem_r [FIFO_DEPTH];
  logic [NOC_DATA_W-1:0] data_mem_r [FIFO_DEPTH][NBEATS];

  logic [IW-1:0]   wr_idx_s, rd_idx_s;
  logic [7:0]      req_type_s, resp_type_s, resp_len_s, head_len_s;
  logic [2:0]      req_size_s;
  logic [63:0]     resp_hdr_s;
  logic            unsupported_s, push_s, pop_s, accept_s, last_beat_s;
  logic [CW-1:0]   cnt_next_s;
  logic            unused_s;

  assign wr_idx_s     = (FIFO_DEPTH > 1) ? wr_ptr_r[IW-1:0] : {IW{1'b0}};
  assign rd_idx_s     = (FIFO_DEPTH > 1) ? rd_ptr_r[IW-1:0] : {IW{1'b0}};
  assign fifo_cnt     = CW'(wr_ptr_r - rd_ptr_r);
  assign in_rdy       = (fifo_cnt != CW'(FIFO_DEPTH));
  assign push_s       = in_val & in_rdy;
  assign flit_out_val = (state_r != ST_IDLE);
  assign accept_s     = flit_out_val & flit_out_rdy;
  assign head_len_s   = hdr_mem_r[rd_idx_s][29:22];
  assign last_beat_s  = (8'(beat_r) == (head_len_s - 8'd1));

  // Translate the incoming request header into the response header and flit count.
  always_comb begin
    req_type_s    = header_in[21:14];
    req_size_s    = header_in[122:120];
    resp_type_s   = 8'd0;
    resp_len_s    = 8'd0;
    unsupported_s = 1'b0;
    case (req_type_s)
      MSG_LOAD_MEM: begin
        resp_type_s = MSG_LOAD_MEM_ACK;
        resp_len_s  = 8'(NBEATS);
      end
      MSG_NC_LOAD_REQ: begin
        resp_type_s = MSG_NC_LOAD_MEM_ACK;
        resp_len_s  = nc_length(req_size_s);
      end
      MSG_STORE_MEM:    resp_type_s = MSG_STORE_MEM_ACK;
      MSG_NC_STORE_REQ: resp_type_s = MSG_NC_STORE_MEM_ACK;
      default: begin
        unsupported_s = 1'b1;
`ifdef NOC_AXI4_BRIDGE_SER_ERR_EN
        resp_type_s   = MSG_NC_STORE_MEM_ACK;
`else
        resp_type_s   = 8'd0;
`endif
        resp_len_s    = 8'd0;
      end
    endcase
    resp_hdr_s = {header_in[191:178], header_in[177:170], header_in[169:162], header_in[161:158],
                  resp_len_s, resp_type_s, header_in[13:6], 6'd0};
  end

`ifdef NOC_AXI4_BRIDGE_SER_ERR_EN
  assign unused_s = ^{header_in[157:123], header_in[119:22], header_in[5:0]};
`else
  assign unused_s = ^{header_in[157:123], header_in[119:22], header_in[5:0], unsupported_s};
`endif

  // Pop when the final flit of the head packet is accepted.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_HDR:  pop_s = accept_s & (head_len_s == 8'd0);
      ST_DATA: pop_s = accept_s & last_beat_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Occupancy after this cycle's push/pop, used to pick HDR vs IDLE without a bubble.
  always_comb begin
    if (push_s && !pop_s) cnt_next_s = fifo_cnt + CW'(1'b1);
    else if (pop_s && !push_s) cnt_next_s = fifo_cnt - CW'(1'b1);
    else cnt_next_s = fifo_cnt;
  end

  // Output mux: header flit straight from the head entry, data flits by beat (optionally swapped).
  always_comb begin
    if (state_r == ST_DATA) begin
      if (SWAP_ENDIANESS != 0) flit_out = swap_bytes(data_mem_r[rd_idx_s][beat_r], chunk_mem_r[rd_idx_s]);
      else flit_out = data_mem_r[rd_idx_s][beat_r];
    end else begin
      flit_out = NOC_DATA_W'(hdr_mem_r[rd_idx_s]);
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(IW + 1){1'b0}};
      rd_ptr_r <= {(IW + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        hdr_mem_r[i]   <= 64'd0;
        chunk_mem_r[i] <= 3'd0;
        for (int b = 0; b < NBEATS; b++) data_mem_r[i][b] <= {NOC_DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        hdr_mem_r[wr_idx_s]   <= resp_hdr_s;
        chunk_mem_r[wr_idx_s] <= chunk_log(req_size_s);
        for (int b = 0; b < NBEATS; b++) data_mem_r[wr_idx_s][b] <= data_in[b*NOC_DATA_W +: NOC_DATA_W];
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Packet sequencer: IDLE -> HDR -> DATA beats, chaining straight into the next header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          beat_r  <= {BW{1'b0}};
          state_r <= (cnt_next_s != {CW{1'b0}}) ? ST_HDR : ST_IDLE;
        end
        ST_HDR: begin
          if (accept_s) begin
            beat_r <= {BW{1'b0}};
            if (head_len_s != 8'd0) state_r <= ST_DATA;
            else state_r <= (cnt_next_s != {CW{1'b0}}) ? ST_HDR : ST_IDLE;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            if (last_beat_s) begin
              beat_r  <= {BW{1'b0}};
              state_r <= (cnt_next_s != {CW{1'b0}}) ? ST_HDR : ST_IDLE;
            end else begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= {BW{1'b0}};
        end
      endcase
    end
  end

`ifdef NOC_AXI4_BRIDGE_SER_ERR_EN
  // One-cycle error pulse after an unsupported request type is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_pulse <= 1'b0;
    else err_pulse <= push_s & unsupported_s;
  end
`else
  assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_noc_axi4_bridge_ser_fifo.sv
// Self-checking bench for noc_axi4_bridge_ser_fifo (built with SWAP_ENDIANESS=1).
module tb_noc_axi4_bridge_ser_fifo;
  localparam int AXI_W = 512, NOC_W = 64, HDR_W = 192, DEPTH = 2, NB = AXI_W / NOC_W;
  localparam logic [7:0] T_NCLD = 8'd14, T_NCST = 8'd15, T_LD = 8'd19, T_ST = 8'd20;
  localparam logic [7:0] A_LD = 8'd24, A_ST = 8'd25, A_NCLD = 8'd26, A_NCST = 8'd27;
`ifdef NOC_AXI4_BRIDGE_SER_ERR_EN
  localparam logic [7:0] A_BAD = A_NCST;
  localparam logic       E_BAD = 1'b1;
`else
  localparam logic [7:0] A_BAD = 8'd0;
  localparam logic       E_BAD = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [HDR_W-1:0] header_in = '0;
  logic [AXI_W-1:0] data_in = '0;
  logic in_val = 1'b0, in_rdy, flit_out_val, flit_out_rdy = 1'b1, err_pulse;
  logic [NOC_W-1:0] flit_out;
  logic [1:0] fifo_cnt;

  always #5 clk = ~clk;

  noc_axi4_bridge_ser_fifo #(.AXI_DATA_W(AXI_W), .NOC_DATA_W(NOC_W), .HDR_W(HDR_W),
                             .FIFO_DEPTH(DEPTH), .SWAP_ENDIANESS(1)) dut (
    .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in), .in_val(in_val),
    .in_rdy(in_rdy), .flit_out(flit_out), .flit_out_val(flit_out_val),
    .flit_out_rdy(flit_out_rdy), .fifo_cnt(fifo_cnt), .err_pulse(err_pulse));

  int total = 0, bad = 0, cyc = 0, acc_cnt = 0;
  logic [63:0] exp_q[$];
  int acc_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AXI_W-1:0] rand_data();
    logic [AXI_W-1:0] r;
    for (int i = 0; i < AXI_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HDR_W-1:0] make_hdr(input logic [7:0] typ, input logic [2:0] sl);
    logic [HDR_W-1:0] h;
    for (int i = 0; i < HDR_W / 32; i++) h[i*32 +: 32] = $urandom;
    h[21:14] = typ;
    h[122:120] = sl;
    return h;
  endfunction

  // Reference model: expected flit list of one packet, built from the packet rules.
  task automatic model_push(input logic [HDR_W-1:0] h, input logic [AXI_W-1:0] d);
    logic [7:0] rtyp;
    logic [63:0] f, g;
    int sl, len, cb;
    sl = int'(h[122:120]);
    case (h[21:14])
      T_LD:   begin rtyp = A_LD;   len = NB; end
      T_ST:   begin rtyp = A_ST;   len = 0;  end
      T_NCLD: begin rtyp = A_NCLD; len = ((1 << sl) + 7) / 8; if (len > NB) len = NB; end
      T_NCST: begin rtyp = A_NCST; len = 0;  end
      default: begin rtyp = A_BAD; len = 0; end
    endcase
    exp_q.push_back({h[191:178], h[177:170], h[169:162], h[161:158], 8'(len), rtyp, h[13:6], 6'd0});
    cb = 1 << sl;
    if (cb > 8) cb = 8;
    for (int k = 0; k < len; k++) begin
      f = d[k*64 +: 64];
      for (int b = 0; b < 8; b++) g[b*8 +: 8] = f[((b / cb) * cb + (cb - 1 - (b % cb))) * 8 +: 8];
      exp_q.push_back(g);
    end
  endtask

  // Monitor: every accepted flit against the model; stalled flits must hold.
  initial begin
    logic prev_stall;
    logic [63:0] prev_flit;
    prev_stall = 1'b0;
    prev_flit = 64'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (prev_stall) begin
          chk("stall_val", 64'(flit_out_val), 64'd1);
          chk("stall_flit", flit_out, prev_flit);
        end
        if (flit_out_val && flit_out_rdy) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_flit: got %h expected no flit", flit_out);
          end else begin
            chk("flit", flit_out, exp_q.pop_front());
          end
          acc_cnt++;
          acc_cyc_q.push_back(cyc);
        end
        prev_stall = flit_out_val && !flit_out_rdy;
        prev_flit = flit_out;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic push(input logic [HDR_W-1:0] h, input logic [AXI_W-1:0] d);
    bit ok;
    ok = 1'b0;
    header_in = h; data_in = d; in_val = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1'b1; model_push(h, d); end
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL push_timeout: got in_rdy=0 expected 1"); end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!flit_out_val && exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_done", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] typ;
    logic [2:0] sl;
    logic [7:0] exp_len;
    logic [7:0] exp_type;
    logic       exp_err;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [HDR_W-1:0] h;
    logic [AXI_W-1:0] d;
    logic [7:0] rtypes[6];
    bit pending;
    int a0;

    vt[0] = '{T_LD,   3'd3, 8'd8, A_LD,   1'b0};
    vt[1] = '{T_ST,   3'd3, 8'd0, A_ST,   1'b0};
    vt[2] = '{T_NCLD, 3'd0, 8'd1, A_NCLD, 1'b0};
    vt[3] = '{T_NCLD, 3'd2, 8'd1, A_NCLD, 1'b0};
    vt[4] = '{T_NCLD, 3'd4, 8'd2, A_NCLD, 1'b0};
    vt[5] = '{T_NCLD, 3'd5, 8'd4, A_NCLD, 1'b0};
    vt[6] = '{T_NCLD, 3'd6, 8'd8, A_NCLD, 1'b0};
    vt[7] = '{T_NCLD, 3'd7, 8'd8, A_NCLD, 1'b0};
    vt[8] = '{T_NCST, 3'd1, 8'd0, A_NCST, 1'b0};
    vt[9] = '{8'hFF,  3'd3, 8'd0, A_BAD,  E_BAD};

    // Reset state
    #12;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_val", 64'(flit_out_val), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: LOAD_MEM with lane values 0..7
    for (int i = 0; i < NB; i++) d[i*64 +: 64] = 64'(i);
    push(make_hdr(T_LD, 3'd0), d);
    for (int k = 0; k <= NB; k++) begin
      @(negedge clk);
      chk("t1_val", 64'(flit_out_val), 64'd1);
      if (k == 0) chk("t1_len", 64'(flit_out[29:22]), 64'd8);
      else chk("t1_data", flit_out, 64'(k - 1));
    end
    @(negedge clk);
    chk("t1_idle", 64'(flit_out_val), 64'd0);
    @(posedge clk); #1;
    drain();

    // Test 2: NC load, 4 bytes, byte-swapped
    d = rand_data();
    d[31:0] = 32'h11223344;
    push(make_hdr(T_NCLD, 3'd2), d);
    @(negedge clk);
    chk("t2_len", 64'(flit_out[29:22]), 64'd1);
    @(negedge clk);
    chk("t2_swap", 64'(flit_out[31:0]), 64'h44332211);
    @(negedge clk);
    chk("t2_idle", 64'(flit_out_val), 64'd0);
    @(posedge clk); #1;
    drain();

    // Table-driven: header LENGTH/TYPE and err_pulse in the cycle after the push
    for (int v = 0; v < 10; v++) begin
      push(make_hdr(vt[v].typ, vt[v].sl), rand_data());
      @(negedge clk);
      chk("tbl_val", 64'(flit_out_val), 64'd1);
      chk("tbl_len", 64'(flit_out[29:22]), 64'(vt[v].exp_len));
      chk("tbl_type", 64'(flit_out[21:14]), 64'(vt[v].exp_type));
      chk("tbl_err", 64'(err_pulse), 64'(vt[v].exp_err));
      @(negedge clk);
      chk("tbl_err_off", 64'(err_pulse), 64'd0);
      @(posedge clk); #1;
      drain();
    end

    // Test 3: fill while stalled, then release
    flit_out_rdy = 1'b0;
    push(make_hdr(T_ST, 3'd0), rand_data());
    push(make_hdr(T_ST, 3'd0), rand_data());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full_rdy", 64'(in_rdy), 64'd0);
      chk("t3_cnt", 64'(fifo_cnt), 64'd2);
      chk("t3_type", 64'(flit_out[21:14]), 64'(A_ST));
    end
    @(posedge clk); #1;
    flit_out_rdy = 1'b1;
    @(negedge clk);
    chk("t3_h1", 64'(flit_out_val), 64'd1);
    chk("t3_cnt2", 64'(fifo_cnt), 64'd2);
    @(negedge clk);
    chk("t3_h2", 64'(flit_out_val), 64'd1);
    chk("t3_h2_type", 64'(flit_out[21:14]), 64'(A_ST));
    chk("t3_cnt1", 64'(fifo_cnt), 64'd1);
    @(negedge clk);
    chk("t3_idle", 64'(flit_out_val), 64'd0);
    @(posedge clk); #1;
    drain();

    // Test 4: three packets stream with no idle cycle
    a0 = acc_cnt;
    push(make_hdr(T_LD, 3'd3), rand_data());
    push(make_hdr(T_ST, 3'd3), rand_data());
    push(make_hdr(T_LD, 3'd3), rand_data());
    drain();
    chk("t4_count", 64'(acc_cnt - a0), 64'd19);
    if (acc_cnt - a0 == 19) chk("t4_span", 64'(acc_cyc_q[a0 + 18] - acc_cyc_q[a0]), 64'd18);

    // Test 5: random traffic and random back-pressure
    rtypes = '{T_LD, T_ST, T_NCLD, T_NCST, 8'h3A, T_LD};
    pending = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        h = make_hdr(rtypes[$urandom_range(0, 5)], 3'($urandom_range(0, 7)));
        d = rand_data();
        header_in = h; data_in = d; in_val = 1'b1; pending = 1'b1;
      end
      flit_out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_val && in_rdy) begin model_push(h, d); pending = 1'b0; end
      @(posedge clk); #1;
      if (!pending) in_val = 1'b0;
    end
    in_val = 1'b0;
    flit_out_rdy = 1'b1;
    drain();

    // Test 6: reset in the middle of the data beats
    for (int i = 0; i < NB; i++) d[i*64 +: 64] = 64'h100 + 64'(i);
    push(make_hdr(T_LD, 3'd0), d);
    repeat (4) @(posedge clk);
    #2;
    chk("t6_beat3", flit_out, 64'h103);
    rst_n = 1'b0;
    #1;
    chk("t6_val_rst", 64'(flit_out_val), 64'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_cnt", 64'(fifo_cnt), 64'd0);
    chk("t6_val", 64'(flit_out_val), 64'd0);
    push(make_hdr(T_NCST, 3'd0), rand_data());
    @(negedge clk);
    chk("t6_hdr_val", 64'(flit_out_val), 64'd1);
    chk("t6_hdr_type", 64'(flit_out[21:14]), 64'(A_NCST));
    @(posedge clk); #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
